rv32_instr_queue: RTL and testbench
===================================

RV32_INSTR_QUEUE -- requirements
Module: rv32_instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter XLEN, default 32, width of pc and instruction fields.
REQ-003 SHALL have ports, one clock, reset asynchronous active-low:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush_in  input  1  discard all entries (branch taken)
- in_valid  input  1  producer (fetch) has an entry
- in_ready  output  1  queue accepts an entry
- pc_in  input  XLEN  entry pc
- instr_in  input  XLEN  entry instruction
- out_valid  output  1  head entry available to decode
- out_ready  input  1  decode consumes head
- pc_out  output  XLEN  head pc
- instr_out  output  XLEN  head instruction
- count_out  output  $clog2(DEPTH)+1  stored entries

Function
REQ-004 SHALL push when in_valid && in_ready && !flush_in; pop when out_valid && out_ready && !flush_in.
REQ-005 SHALL drive in_ready = (count < DEPTH), independent of out_ready; full queue with simultaneous pop does not accept.
REQ-006 SHALL drive out_valid = (count > 0) && !flush_in, except as extended by REQ-015.
REQ-007 SHALL present the oldest entry on pc_out/instr_out; order strictly FIFO.
REQ-008 SHALL make a pushed entry visible at outputs no earlier than the next cycle (latency 1) without the macro.
REQ-009 SHALL update count: +1 push only, -1 pop only, unchanged for push+pop or neither.
REQ-010 SHALL wrap read and write pointers modulo DEPTH.
REQ-011 SHALL, on flush_in high at a clock edge, set count and both pointers to 0, ignoring any concurrent push or pop.
REQ-012 SHALL hold all state when neither push, pop nor flush occurs.
REQ-013 SHALL keep count_out registered, equal to stored entries.

Reset
REQ-014 SHALL on reset_n low immediately set: pointers 0, count_out 0, out_valid 0, in_ready 1, storage 0 (so pc_out = instr_out = 0); deassertion mid-stream resumes from empty.

Configuration
REQ-015 SHALL, with RV32_INSTR_QUEUE_BYPASS_EN defined, when count == 0 and in_valid and !flush_in, assert out_valid combinationally with pc_out/instr_out = pc_in/instr_in; if out_ready the entry is consumed and not stored (count stays 0), else it is stored normally.
REQ-016 SHALL, without RV32_INSTR_QUEUE_BYPASS_EN, have no combinational path from in_* to out_*.

Structure
REQ-017 SHALL take XLEN default and fetch entry struct (pc, instr) from shared package rv32_pkg.
REQ-018 SHALL use no sub-module; storage is an internal DEPTH-entry array with inline pointers.

Verification
REQ-019 Fill: DEPTH=4, out_ready=0, push pc 0x00,0x04,0x08,0x0C -> count_out 4, in_ready 0; fifth push not accepted.
REQ-020 Drain order: then out_ready=1 for 4 cycles -> pc_out 0x00,0x04,0x08,0x0C in order, count_out 0, out_valid 0.
REQ-021 Wrap: 10 push/pop pairs through DEPTH=4 at steady count 2 -> no loss, order preserved, count_out constant 2.
REQ-022 Flush: count 3, flush_in with in_valid=1 (pc 0x40) -> next cycle count_out 0, out_valid 0, 0x40 not stored.
REQ-023 Reset mid-operation: count 2, reset_n low -> count_out 0, out_valid 0, pc_out 0 immediately without clock.
REQ-024 Bypass (macro defined): empty, in_valid=1 pc 0x80, out_ready=1 -> same cycle out_valid 1, pc_out 0x80, count_out stays 0; undefined -> out_valid 0 that cycle, 0x80 at output next cycle.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: default datapath width and the fetch entry
// record carried from fetch to decode.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] pc,
                                              input logic [XLEN-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/rv32_instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO with flush on taken branch.
// Optional same-cycle bypass when empty: define RV32_INSTR_QUEUE_BYPASS_EN.
module rv32_instr_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rv32_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          pc_in,
  input  logic [XLEN-1:0]          instr_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          instr_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  // Handshake: a transfer happens on a rising edge where valid && ready && !flush_in.
  // in_ready depends only on occupancy, so a full queue never accepts, even while
  // decode is popping in the same cycle.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic               push, pop;
  logic               push_store, pop_mem;
  logic               bypass;
  fetch_entry_t       head;

  assign head     = mem_q[rd_ptr_q];
  assign in_ready = (count_q < CW'(DEPTH));

`ifdef RV32_INSTR_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && in_valid && !flush_in;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ((count_q != '0) && !flush_in) || bypass;
  assign pc_out    = bypass ? pc_in    : head.pc;
  assign instr_out = bypass ? instr_in : head.instr;
  assign count_out = count_q;

  assign push = in_valid  && in_ready  && !flush_in;
  assign pop  = out_valid && out_ready && !flush_in;

  // A bypassed entry taken by decode this cycle never lands in storage; when the
  // queue is empty the pop can only be that bypassed entry.
  assign push_store = push && !(bypass && out_ready);
  assign pop_mem    = pop && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_store) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_mem)    rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_store, pop_mem})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_store && !flush_in) begin
        mem_q[wr_ptr_q] <= make_entry(pc_in, instr_in);
      end
    end
  end

endmodule

// File: tb/tb_rv32_instr_queue.sv
// Directed bench for rv32_instr_queue (DEPTH=4, XLEN=32); honours
// RV32_INSTR_QUEUE_BYPASS_EN for the empty-queue latency check.
module tb_rv32_instr_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic             clk;
  logic             reset_n;
  logic             flush_in;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  pc_in;
  logic [XLEN-1:0]  instr_in;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  instr_out;
  logic [2:0]       count_out;

  int n_checks;
  int n_errors;
  logic [XLEN-1:0] exp_q[$];

  rv32_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .count_out (count_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs checked 1ns later
  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic rdy,
                       input logic fl);
    in_valid  = v;
    pc_in     = pc;
    instr_in  = instr_of(pc);
    out_ready = rdy;
    flush_in  = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle();
    #12;
    check("rst_count",     32'(count_out), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_pc_out",    pc_out,         32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // fill with decode stalled
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
      check("fill_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    check("fill_count",    32'(count_out), 32'd4);
    check("fill_in_ready_full", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    step();
    check("fill_fifth_count", 32'(count_out), 32'd4);
    check("fill_head_pc",     pc_out,         32'h00);

    // drain in order
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc",    pc_out,         32'(i * 4));
      check("drain_instr", instr_out,      instr_of(32'(i * 4)));
      step();
    end
    idle();
    check("drain_count", 32'(count_out), 32'd0);
    check("drain_valid_empty", 32'(out_valid), 32'd0);

    // first-entry latency into an empty queue
    drive(1'b1, 32'h80, 1'b1, 1'b0);
`ifdef RV32_INSTR_QUEUE_BYPASS_EN
    check("byp_valid_same", 32'(out_valid), 32'd1);
    check("byp_pc_same",    pc_out,         32'h80);
    step();
    idle();
    check("byp_count", 32'(count_out), 32'd0);
    check("byp_valid_next", 32'(out_valid), 32'd0);
`else
    check("lat_valid_same", 32'(out_valid), 32'd0);
    step();
    idle();
    check("lat_count",      32'(count_out), 32'd1);
    check("lat_valid_next", 32'(out_valid), 32'd1);
    check("lat_pc_next",    pc_out,         32'h80);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    idle();
    check("lat_drained", 32'(count_out), 32'd0);
`endif

    // wrap: steady occupancy of 2 through 10 push/pop pairs
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
      exp_q.push_back(pc_in);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h108 + 32'(k * 4), 1'b1, 1'b0);
      exp_q.push_back(pc_in);
      check("wrap_pc",   pc_out, exp_q.pop_front());
      step();
      check("wrap_count", 32'(count_out), 32'd2);
    end
    while (exp_q.size() > 0) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("wrap_tail_pc", pc_out, exp_q.pop_front());
      step();
    end
    idle();
    check("wrap_empty", 32'(count_out), 32'd0);

    // full queue with simultaneous pop does not accept
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h300, 1'b1, 1'b0);
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    step();
    idle();
    check("full_pop_count", 32'(count_out), 32'd3);
    check("full_pop_head",  pc_out,         32'h204);

    // flush at count 3 with a concurrent push
    drive(1'b1, 32'h40, 1'b1, 1'b1);
    check("flush_valid_during", 32'(out_valid), 32'd0);
    step();
    idle();
    check("flush_count", 32'(count_out), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    step();
    check("flush_not_stored", 32'(count_out), 32'd0);

    // asynchronous reset mid-stream, then resume from empty
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    idle();
    check("pre_rst_count", 32'(count_out), 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count_out), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pc",    pc_out,         32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 32'h600, 1'b0, 1'b0);
    step();
    idle();
    check("resume_count", 32'(count_out), 32'd1);
    check("resume_pc",    pc_out,         32'h600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
